mult_issue: RTL and testbench
=============================

MULT_ISSUE -- requirements
Module: mult_issue

Interface
REQ-001 Parameter TIMEOUT, default 20, SHALL set the max RUN-state cycles waited for m_resultRDY before abort.
REQ-002 Parameter DW, default 32, SHALL set operand/result width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset; rst=0 SHALL reset the block immediately, independent of clk.
REQ-005 ctrl_MULT  in  1  start request, sampled on rising edge.
REQ-006 data_operandA / data_operandB  in  DW each  multiplicand / multiplier, sampled with an accepted ctrl_MULT.
REQ-007 busy  out  1  high in CLEAR, RUN and DONE.
REQ-008 data_result  out  DW  registered product; data_exception  out  1  registered overflow flag; timeout  out  1  registered abort flag.
REQ-009 result_valid  out  1 / result_ready  in  1  downstream valid/ready handshake.
REQ-010 m_operandA / m_operandB  out  DW  held operands to the iterative multiplier; m_rst  out  1  active-high multiplier clear.
REQ-011 m_result  in  DW, m_exception  in  1, m_resultRDY  in  1  multiplier outputs.

Function
REQ-012 States SHALL be IDLE, CLEAR, RUN, DONE; encoding is free.
REQ-013 IDLE: ctrl_MULT=1 SHALL latch both operands into m_operandA/B and go to CLEAR.
REQ-014 CLEAR: m_rst SHALL be 1 for exactly one cycle; next state RUN.
REQ-015 m_operandA/B SHALL be held constant from CLEAR through the RUN->DONE transition.
REQ-016 RUN: a 5-bit-minimum watchdog SHALL count cycles from 0; m_resultRDY=1 SHALL capture m_result and m_exception into data_result/data_exception, clear timeout, and go to DONE.
REQ-017 RUN: watchdog reaching TIMEOUT-1 without m_resultRDY SHALL load data_result=0, data_exception=1, timeout=1, and go to DONE.
REQ-018 m_resultRDY outside RUN SHALL be ignored.
REQ-019 DONE: result_valid SHALL be 1; data_result, data_exception and timeout SHALL stay stable until result_ready=1.
REQ-020 DONE with result_ready=1 and ctrl_MULT=0 SHALL go to IDLE.
REQ-021 DONE with result_ready=1 and ctrl_MULT=1 on the same edge SHALL latch the new operands and go directly to CLEAR (back-to-back issue).
REQ-022 ctrl_MULT in CLEAR, RUN, or DONE without result_ready SHALL be ignored; operands SHALL not change.
REQ-023 result_valid SHALL be 0 in every state except DONE.
REQ-024 Latency, multiplier with m_resultRDY 16 cycles after m_rst release: start edge N -> CLEAR N+1 -> RUN N+2 -> result_valid high after edge N+17.
REQ-025 Outputs data_result/data_exception/timeout SHALL retain their last value in IDLE.

Reset
REQ-026 While rst=0: state IDLE, busy=0, result_valid=0, data_result=0, data_exception=0, timeout=0, m_operandA/B=0, watchdog=0.
REQ-027 m_rst SHALL equal 1 whenever rst=0 (combinationally), in addition to the CLEAR cycle.
REQ-028 Reset asserted mid-RUN or mid-DONE SHALL abandon the operation; no result_valid SHALL follow reset release without a new ctrl_MULT.
REQ-029 First ctrl_MULT sampled on the first rising edge after rst rises SHALL be accepted.

Verification
REQ-030 A=7, B=6, one-cycle ctrl_MULT, result_ready=1 -> m_rst one pulse, result_valid after 17 further edges, data_result=42, data_exception=0, timeout=0.
REQ-031 A=-3 (0xFFFFFFFD), B=5, result_ready held 0 for 5 cycles -> data_result=0xFFFFFFF1 held stable over those 5 cycles, result_valid drops one edge after result_ready=1.
REQ-032 A=0x00010000, B=0x00010000 -> data_result=0, data_exception=1, timeout=0.
REQ-033 m_resultRDY forced 0 -> after TIMEOUT=20 RUN cycles: result_valid=1, data_result=0, data_exception=1, timeout=1.
REQ-034 rst=0 pulsed on RUN cycle 8 -> immediate busy=0, m_rst=1, all outputs zero; no result_valid until a new start.
REQ-035 ctrl_MULT=1 with result_ready=1 in DONE (A=2,B=3 then A=4,B=5) -> DONE->CLEAR direct, results 6 then 20; extra ctrl_MULT pulses during RUN ignored.

Source files
------------

// File: rtl/mult_issue_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_issue_if
// Description : Issue-side request/result bus plus iterative-multiplier bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_issue_if #(
    parameter int DW = 32
);
    logic          ctrl_MULT;
    logic [DW-1:0] data_operandA;
    logic [DW-1:0] data_operandB;
    logic          busy;
    logic [DW-1:0] data_result;
    logic          data_exception;
    logic          timeout;
    logic          result_valid;
    logic          result_ready;
    logic [DW-1:0] m_operandA;
    logic [DW-1:0] m_operandB;
    logic          m_rst;
    logic [DW-1:0] m_result;
    logic          m_exception;
    logic          m_resultRDY;

    // Issue controller view
    modport slave (
        input  ctrl_MULT, data_operandA, data_operandB, result_ready,
               m_result, m_exception, m_resultRDY,
        output busy, data_result, data_exception, timeout, result_valid,
               m_operandA, m_operandB, m_rst
    );

    // Requester + multiplier (environment) view
    modport master (
        output ctrl_MULT, data_operandA, data_operandB, result_ready,
               m_result, m_exception, m_resultRDY,
        input  busy, data_result, data_exception, timeout, result_valid,
               m_operandA, m_operandB, m_rst
    );
endinterface
`default_nettype wire

// File: rtl/mult_issue.sv
`default_nettype none
// ============================================================================
// Module      : mult_issue
// Description : Issues operands to an iterative multiplier, waits with a
//               watchdog, and presents the result on a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_issue #(
    parameter int TIMEOUT = 20,
    parameter int DW      = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    mult_issue_if.slave bus
);
    localparam int c_WD_W = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_accept;
    logic              w_capture;
    logic              w_abort;
    logic [c_WD_W-1:0] r_wd;
    logic [DW-1:0]     r_op_a;
    logic [DW-1:0]     r_op_b;
    logic [DW-1:0]     r_result;
    logic              r_exception;
    logic              r_timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.ctrl_MULT) begin
                    w_accept     = 1'b1;
                    w_state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_state_next = S_RUN;
            end
            S_RUN: begin
                // A ready result on the last watchdog cycle still wins over abort
                if (bus.m_resultRDY) begin
                    w_capture    = 1'b1;
                    w_state_next = S_DONE;
                end else if (r_wd == c_WD_LAST) begin
                    w_abort      = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.result_ready) begin
                    if (bus.ctrl_MULT) begin
                        w_accept     = 1'b1;
                        w_state_next = S_CLEAR;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd        <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_result    <= '0;
            r_exception <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_wd <= (r_state == S_RUN) ? r_wd + 1'b1 : '0;
            if (w_accept) begin
                r_op_a <= bus.data_operandA;
                r_op_b <= bus.data_operandB;
            end
            if (w_capture) begin
                r_result    <= bus.m_result;
                r_exception <= bus.m_exception;
                r_timeout   <= 1'b0;
            end else if (w_abort) begin
                r_result    <= '0;
                r_exception <= 1'b1;
                r_timeout   <= 1'b1;
            end
        end
    end

    // Multiplier clear is held during reset as well as for the CLEAR cycle
    assign bus.m_rst          = ~rst | (r_state == S_CLEAR);
    assign bus.busy           = (r_state != S_IDLE);
    assign bus.result_valid   = (r_state == S_DONE);
    assign bus.m_operandA     = r_op_a;
    assign bus.m_operandB     = r_op_b;
    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exception;
    assign bus.timeout        = r_timeout;
endmodule
`default_nettype wire

// File: tb/tb_mult_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_issue
// Description : Self-checking bench for mult_issue with a multiplier model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_issue;
    localparam int c_TIMEOUT = 20;
    localparam int c_DW      = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    mult_issue_if #(.DW(c_DW)) bus ();

    mult_issue #(.TIMEOUT(c_TIMEOUT), .DW(c_DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Multiplier model: result ready on the mul_lat-th cycle after clear release
    int unsigned        mul_cnt = 0;
    int unsigned        mul_lat = 16;
    logic signed [63:0] w_ea;
    logic signed [63:0] w_eb;
    logic signed [63:0] w_prod;

    always @(posedge clk) begin
        if (bus.m_rst) mul_cnt <= 0;
        else if (mul_cnt < 1000) mul_cnt <= mul_cnt + 1;
    end

    assign w_ea            = {{32{bus.m_operandA[31]}}, bus.m_operandA};
    assign w_eb            = {{32{bus.m_operandB[31]}}, bus.m_operandB};
    assign w_prod          = w_ea * w_eb;
    assign bus.m_result    = w_prod[31:0];
    assign bus.m_exception = (w_prod != {{32{w_prod[31]}}, w_prod[31:0]});
    assign bus.m_resultRDY = !bus.m_rst && (mul_cnt + 1 >= mul_lat);

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          hold;
        logic [31:0] res;
        logic        exc;
        logic        to;
        int          edges;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: signed product truncated to DW, overflow when it leaves signed range
    task automatic ref_model(input logic [31:0] a, input logic [31:0] b, input int lat,
                             output logic [31:0] res, output logic exc, output logic to,
                             output int edges);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        if (lat > c_TIMEOUT) begin
            res = 32'h0; exc = 1'b1; to = 1'b1; edges = 2 + c_TIMEOUT;
        end else begin
            res = p[31:0];
            exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
            to = 1'b0; edges = 2 + lat;
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.result_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input string nm, input bit sync, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int hold, input logic [31:0] er, input logic ee,
                          input logic et, input int eedges);
        int edges = 0;
        int mrst_cnt = 0;
        int opsbad = 0;
        int holdbad = 0;
        bit got = 0;
        if (sync) @(negedge clk);
        mul_lat            = lat;
        bus.ctrl_MULT      = 1'b1;
        bus.data_operandA  = a;
        bus.data_operandB  = b;
        bus.result_ready   = (hold == 0);
        while (!got && edges < 100) begin
            @(negedge clk);
            edges++;
            bus.ctrl_MULT     = 1'b0;
            bus.data_operandA = $urandom;
            bus.data_operandB = $urandom;
            if (bus.m_rst) mrst_cnt++;
            if (bus.busy && (bus.m_operandA !== a || bus.m_operandB !== b)) opsbad++;
            if (bus.result_valid) got = 1;
        end
        check({nm, " valid_seen"}, 64'(got), 64'd1);
        check({nm, " latency"}, 64'(edges), 64'(eedges));
        check({nm, " m_rst_pulses"}, 64'(mrst_cnt), 64'd1);
        check({nm, " operands_held"}, 64'(opsbad), 64'd0);
        check({nm, " result"}, 64'(bus.data_result), 64'(er));
        check({nm, " exception"}, 64'(bus.data_exception), 64'(ee));
        check({nm, " timeout"}, 64'(bus.timeout), 64'(et));
        for (int i = 0; i < hold; i++) begin
            bus.ctrl_MULT     = 1'b1;
            bus.data_operandA = $urandom;
            @(negedge clk);
            if (!bus.result_valid || bus.data_result !== er || bus.data_exception !== ee ||
                bus.timeout !== et || bus.m_operandA !== a) holdbad++;
        end
        if (hold > 0) check({nm, " stable_in_done"}, 64'(holdbad), 64'd0);
        bus.ctrl_MULT    = 1'b0;
        bus.result_ready = 1'b1;
        @(negedge clk);
        check({nm, " valid_drop"}, {62'd0, bus.result_valid, bus.busy}, 64'd0);
        check({nm, " idle_retain"}, 64'(bus.data_result), 64'(er));
    endtask

    initial begin
        int n;
        int vcount;
        logic [31:0] ra, rb, er;
        logic ee, et;
        int lat, hold, eedges;

        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = 32'h0;
        bus.data_operandB = 32'h0;
        bus.result_ready  = 1'b0;

        tbl[0] = '{32'd7,        32'd6,        16, 0, 32'd42,       1'b0, 1'b0, 18};
        tbl[1] = '{32'hFFFFFFFD, 32'd5,        16, 5, 32'hFFFFFFF1, 1'b0, 1'b0, 18};
        tbl[2] = '{32'h00010000, 32'h00010000, 16, 0, 32'h0,        1'b1, 1'b0, 18};
        tbl[3] = '{32'd1,        32'd1,        63, 2, 32'h0,        1'b1, 1'b1, 22};
        tbl[4] = '{32'h7FFFFFFF, 32'd2,         3, 1, 32'hFFFFFFFE, 1'b1, 1'b0,  5};
        tbl[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 20, 0, 32'd1,        1'b0, 1'b0, 22};
        tbl[6] = '{32'd5,        32'd5,        21, 0, 32'h0,        1'b1, 1'b1, 22};
        tbl[7] = '{32'h80000000, 32'hFFFFFFFF,  1, 0, 32'h80000000, 1'b1, 1'b0,  3};
        tbl[8] = '{32'h00012345, 32'd0,         2, 3, 32'h0,        1'b0, 1'b0,  4};

        @(negedge clk);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset valid", 64'(bus.result_valid), 64'd0);
        check("reset m_rst", 64'(bus.m_rst), 64'd1);
        check("reset outputs", {bus.data_result, 29'd0, bus.data_exception, bus.timeout, 1'b0}, 64'd0);
        check("reset operands", {bus.m_operandA, bus.m_operandB}, 64'd0);

        // Release reset and start on the very next rising edge
        rst = 1'b1;
        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), i != 0, tbl[i].a, tbl[i].b, tbl[i].lat, tbl[i].hold,
                   tbl[i].res, tbl[i].exc, tbl[i].to, tbl[i].edges);
        end

        for (int i = 0; i < 25; i++) begin
            ra   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 2000)) - 32'd1000;
            rb   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 2000)) - 32'd1000;
            lat  = $urandom_range(1, c_TIMEOUT + 3);
            hold = $urandom_range(0, 3);
            ref_model(ra, rb, lat, er, ee, et, eedges);
            run_op($sformatf("rnd%0d", i), 1'b1, ra, rb, lat, hold, er, ee, et, eedges);
        end

        // Back-to-back issue from DONE, with an ignored start pulse during RUN
        @(negedge clk);
        mul_lat = 5;
        bus.ctrl_MULT = 1'b1; bus.data_operandA = 32'd2; bus.data_operandB = 32'd3;
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.ctrl_MULT = 1'b0;
        wait_valid(n);
        check("b2b first_result", 64'(bus.data_result), 64'd6);
        bus.ctrl_MULT = 1'b1; bus.data_operandA = 32'd4; bus.data_operandB = 32'd5;
        @(negedge clk);
        bus.ctrl_MULT = 1'b0;
        check("b2b direct_clear", {61'd0, bus.result_valid, bus.m_rst, bus.busy}, 64'd3);
        check("b2b new_operands", {bus.m_operandA, bus.m_operandB}, {32'd4, 32'd5});
        @(negedge clk);
        bus.ctrl_MULT = 1'b1; bus.data_operandA = 32'd99; bus.data_operandB = 32'd99;
        @(negedge clk);
        bus.ctrl_MULT = 1'b0;
        check("b2b ignore_in_run", {bus.m_operandA, bus.m_operandB}, {32'd4, 32'd5});
        wait_valid(n);
        check("b2b second_result", {bus.data_result, 31'd0, bus.timeout}, {32'd20, 32'd0});
        @(negedge clk);
        check("b2b to_idle", {62'd0, bus.result_valid, bus.busy}, 64'd0);

        // Reset pulse on RUN cycle 8 abandons the operation
        mul_lat = 16;
        bus.ctrl_MULT = 1'b1; bus.data_operandA = 32'd9; bus.data_operandB = 32'd9;
        @(negedge clk);
        bus.ctrl_MULT = 1'b0;
        repeat (9) @(negedge clk);
        check("rstrun busy_before", 64'(bus.busy), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("rstrun busy", 64'(bus.busy), 64'd0);
        check("rstrun m_rst", 64'(bus.m_rst), 64'd1);
        check("rstrun outputs", {bus.data_result, 29'd0, bus.data_exception, bus.timeout, bus.result_valid}, 64'd0);
        check("rstrun operands", {bus.m_operandA, bus.m_operandB}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.result_valid || bus.busy) vcount++;
        end
        check("rstrun no_valid_after", 64'(vcount), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit actual=expired required=finished");
        $fatal(1, "time limit");
    end
endmodule
`default_nettype wire
